page_table_walker: RTL and testbench

Two-level hardware page table walker that sits between the TLB miss path and the memory unit. It accepts a virtual address from the TLB and issues up to two word reads to memory over the memory request/response handshake, acting as the initiator on that interface. It decodes each PTE and returns either a physical page number with permissions or a fault.

---
 rtl/tlb_pkg.sv | 35 +++
 rtl/page_table_walker_if.sv | 37 +++
 rtl/page_table_walker_pte_decode.sv | 33 +++
 rtl/page_table_walker.sv | 163 ++++++++++++++++
 tb/tb_page_table_walker.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/tlb_pkg.sv
// Shared definitions for the TLB miss path: PTE layout, walker states and PTE classification.
package tlb_pkg;

    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;

    localparam int PAGE_SHIFT = 12;
    localparam int VPN_W      = 10;
    localparam int PPN_W      = 20;

    localparam logic [31:0] PTE_BASE_MASK = 32'hFFFF_FFF0;

    typedef enum logic [2:0] {
        IDLE,
        L1_REQ,
        L1_WAIT,
        L2_REQ,
        L2_WAIT,
        RESP
    } ptw_state_e;

    typedef enum logic [1:0] {
        PTE_INVALID,
        PTE_POINTER,
        PTE_LEAF
    } pte_kind_e;

    // Byte address of the 4-byte PTE selected by vpn inside the table at base (wraps mod 2^32).
    function automatic logic [31:0] pte_addr(input logic [31:0] base, input logic [VPN_W-1:0] vpn);
        return base + {{(32-VPN_W-2){1'b0}}, vpn, 2'b00};
    endfunction

endpackage

// File: rtl/page_table_walker_if.sv
// Walk request/response and memory read channels of the page table walker.
interface page_table_walker_if;

    logic        walk_req_valid_i;
    logic        walk_req_ready_o;
    logic [31:0] walk_vaddr_i;
    logic        walk_resp_valid_o;
    logic        walk_resp_ready_i;
    logic [19:0] walk_ppn_o;
    logic [2:0]  walk_perm_o;
    logic        walk_super_o;
    logic        walk_fault_o;

    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_addr_o;
    logic        mem_resp_valid_i;
    logic        mem_resp_ready_o;
    logic [31:0] mem_data_i;

    modport master (
        input  walk_req_valid_i, walk_vaddr_i, walk_resp_ready_i,
        input  mem_req_ready_i, mem_resp_valid_i, mem_data_i,
        output walk_req_ready_o, walk_resp_valid_o, walk_ppn_o, walk_perm_o,
        output walk_super_o, walk_fault_o,
        output mem_req_valid_o, mem_addr_o, mem_resp_ready_o
    );

    modport slave (
        output walk_req_valid_i, walk_vaddr_i, walk_resp_ready_i,
        output mem_req_ready_i, mem_resp_valid_i, mem_data_i,
        input  walk_req_ready_o, walk_resp_valid_o, walk_ppn_o, walk_perm_o,
        input  walk_super_o, walk_fault_o,
        input  mem_req_valid_o, mem_addr_o, mem_resp_ready_o
    );

endinterface

// File: rtl/page_table_walker_pte_decode.sv
// Combinational PTE classifier, shared with the TLB refill path.
module pte_decode
    import tlb_pkg::*;
(
    input  logic [31:0]      pte_i,
    input  logic             level1_i,
    output pte_kind_e        kind_o,
    output logic [PPN_W-1:0] ppn_o,
    output logic [2:0]       perm_o
);

    logic unused_pte_bits;
    assign unused_pte_bits = ^pte_i[PAGE_SHIFT-1:4];

    always_comb begin
        kind_o = PTE_INVALID;
        ppn_o  = '0;
        perm_o = '0;
        // W without R is a reserved encoding and is treated like V=0.
        if (pte_i[PTE_V] && !(pte_i[PTE_W] && !pte_i[PTE_R])) begin
            if (!pte_i[PTE_R] && !pte_i[PTE_W] && !pte_i[PTE_X]) begin
                kind_o = PTE_POINTER;
            end else if (level1_i && (pte_i[PAGE_SHIFT+VPN_W-1:PAGE_SHIFT] != '0)) begin
                kind_o = PTE_INVALID;
            end else begin
                kind_o = PTE_LEAF;
                ppn_o  = pte_i[31:PAGE_SHIFT];
                perm_o = {pte_i[PTE_X], pte_i[PTE_W], pte_i[PTE_R]};
            end
        end
    end

endmodule

// File: rtl/page_table_walker.sv
// Two-level page table walker: one or two PTE reads per TLB miss, returns ppn/perm or a fault.
module page_table_walker
    import tlb_pkg::*;
#(
    parameter logic [31:0] ROOT_BASE = 32'h0000_0400
) (
    input  logic               clk,
    input  logic               rst,
    page_table_walker_if.master bus
);

    ptw_state_e        state_q, state_d;
    logic [19:0]       vpn_q, vpn_d;
    logic [31:0]       base_q, base_d;
    logic [PPN_W-1:0]  ppn_q, ppn_d;
    logic [2:0]        perm_q, perm_d;
    logic              super_q, super_d;
    logic              fault_q, fault_d;
    logic              walk_req_ready_q, walk_req_ready_d;
    logic              walk_resp_valid_q, walk_resp_valid_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic              mem_resp_ready_q, mem_resp_ready_d;
    logic [31:0]       mem_addr_q, mem_addr_d;

    pte_kind_e         dec_kind;
    logic [PPN_W-1:0]  dec_ppn;
    logic [2:0]        dec_perm;

    logic unused_vaddr_bits;
    assign unused_vaddr_bits = ^bus.walk_vaddr_i[PAGE_SHIFT-1:0];

    pte_decode u_pte_decode (
        .pte_i    (bus.mem_data_i),
        .level1_i (state_q == L1_WAIT),
        .kind_o   (dec_kind),
        .ppn_o    (dec_ppn),
        .perm_o   (dec_perm)
    );

    always_comb begin
        state_d  = state_q;
        vpn_d    = vpn_q;
        base_d   = base_q;
        ppn_d    = ppn_q;
        perm_d   = perm_q;
        super_d  = super_q;
        fault_d  = fault_q;

        case (state_q)
            IDLE: begin
                if (bus.walk_req_valid_i && walk_req_ready_q) begin
                    vpn_d   = bus.walk_vaddr_i[31:PAGE_SHIFT];
                    state_d = L1_REQ;
                end
            end
            L1_REQ: begin
                if (bus.mem_req_ready_i) state_d = L1_WAIT;
            end
            L1_WAIT: begin
                if (bus.mem_resp_valid_i) begin
                    state_d = RESP;
                    ppn_d   = '0;
                    perm_d  = '0;
                    super_d = 1'b0;
                    fault_d = 1'b0;
                    case (dec_kind)
                        PTE_POINTER: begin
                            base_d  = bus.mem_data_i & PTE_BASE_MASK;
                            state_d = L2_REQ;
                        end
                        // Superpage: low ppn bits come from the VA, the PTE's must be zero.
                        PTE_LEAF: begin
                            ppn_d   = {dec_ppn[PPN_W-1:VPN_W], vpn_q[VPN_W-1:0]};
                            perm_d  = dec_perm;
                            super_d = 1'b1;
                        end
                        default: fault_d = 1'b1;
                    endcase
                end
            end
            L2_REQ: begin
                if (bus.mem_req_ready_i) state_d = L2_WAIT;
            end
            L2_WAIT: begin
                if (bus.mem_resp_valid_i) begin
                    state_d = RESP;
                    super_d = 1'b0;
                    if (dec_kind == PTE_LEAF) begin
                        ppn_d   = dec_ppn;
                        perm_d  = dec_perm;
                        fault_d = 1'b0;
                    end else begin
                        ppn_d   = '0;
                        perm_d  = '0;
                        fault_d = 1'b1;
                    end
                end
            end
            RESP: begin
                if (bus.walk_resp_ready_i) begin
                    state_d = IDLE;
                    ppn_d   = '0;
                    perm_d  = '0;
                    super_d = 1'b0;
                    fault_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered, so they are derived from the next state.
        walk_req_ready_d  = (state_d == IDLE);
        walk_resp_valid_d = (state_d == RESP);
        mem_req_valid_d   = (state_d == L1_REQ) || (state_d == L2_REQ);
        mem_resp_ready_d  = (state_d == L1_WAIT) || (state_d == L2_WAIT);
        case (state_d)
            L1_REQ:  mem_addr_d = pte_addr(ROOT_BASE, vpn_d[19:VPN_W]);
            L2_REQ:  mem_addr_d = pte_addr(base_d, vpn_d[VPN_W-1:0]);
            default: mem_addr_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q           <= IDLE;
            vpn_q             <= '0;
            base_q            <= '0;
            ppn_q             <= '0;
            perm_q            <= '0;
            super_q           <= 1'b0;
            fault_q           <= 1'b0;
            walk_req_ready_q  <= 1'b0;
            walk_resp_valid_q <= 1'b0;
            mem_req_valid_q   <= 1'b0;
            mem_resp_ready_q  <= 1'b0;
            mem_addr_q        <= '0;
        end else begin
            state_q           <= state_d;
            vpn_q             <= vpn_d;
            base_q            <= base_d;
            ppn_q             <= ppn_d;
            perm_q            <= perm_d;
            super_q           <= super_d;
            fault_q           <= fault_d;
            walk_req_ready_q  <= walk_req_ready_d;
            walk_resp_valid_q <= walk_resp_valid_d;
            mem_req_valid_q   <= mem_req_valid_d;
            mem_resp_ready_q  <= mem_resp_ready_d;
            mem_addr_q        <= mem_addr_d;
        end
    end

    assign bus.walk_req_ready_o  = walk_req_ready_q;
    assign bus.walk_resp_valid_o = walk_resp_valid_q;
    assign bus.walk_ppn_o        = ppn_q;
    assign bus.walk_perm_o       = perm_q;
    assign bus.walk_super_o      = super_q;
    assign bus.walk_fault_o      = fault_q;
    assign bus.mem_req_valid_o   = mem_req_valid_q;
    assign bus.mem_addr_o        = mem_addr_q;
    assign bus.mem_resp_ready_o  = mem_resp_ready_q;

endmodule

// File: tb/tb_page_table_walker.sv
// Directed bench for page_table_walker: vector table of walks plus backpressure and mid-walk reset sequences.
module tb_page_table_walker;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    page_table_walker_if bus ();

    page_table_walker #(.ROOT_BASE(32'h0000_0400)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] addr_log[$];

    typedef struct {
        logic [31:0] vaddr;
        logic [19:0] ppn;
        logic [2:0]  perm;
        logic        sup;
        logic        fault;
        int          nreads;
        logic [31:0] a0;
        logic [31:0] a1;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    // Standard image plus a few level-1 leaves and a level-2 pointer for the corner cases.
    function automatic logic [31:0] mem_read(input logic [31:0] a);
        case (a)
            32'h400: return 32'h0000_0801;
            32'h404: return 32'h1234_0000;
            32'h408: return 32'h0000_0000;
            32'h40C: return 32'h0040_000B;
            32'h410: return 32'h0040_1003;
            32'h414: return 32'h0000_0005;
            32'h800: return 32'h1000_000F;
            32'h804: return 32'h1100_000F;
            32'h808: return 32'h1200_0007;
            32'h80C: return 32'h0000_0000;
            32'h810: return 32'h0000_0801;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Memory: responds the cycle after accepting a request, logs every accepted address.
    always @(posedge clk) begin
        if (!rst) begin
            bus.mem_resp_valid_i <= 1'b0;
        end else begin
            if (bus.mem_resp_valid_i && bus.mem_resp_ready_o) bus.mem_resp_valid_i <= 1'b0;
            if (bus.mem_req_valid_o && bus.mem_req_ready_i) begin
                bus.mem_resp_valid_i <= 1'b1;
                bus.mem_data_i       <= mem_read(bus.mem_addr_o);
                addr_log.push_back(bus.mem_addr_o);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"},  {31'b0, bus.walk_req_ready_o},  32'd0);
        check({tag, "_resp_valid"}, {31'b0, bus.walk_resp_valid_o}, 32'd0);
        check({tag, "_mem_valid"},  {31'b0, bus.mem_req_valid_o},   32'd0);
        check({tag, "_mem_rready"}, {31'b0, bus.mem_resp_ready_o},  32'd0);
        check({tag, "_mem_addr"},   bus.mem_addr_o,                 32'd0);
        check({tag, "_ppn"},        {12'b0, bus.walk_ppn_o},        32'd0);
        check({tag, "_fault"},      {31'b0, bus.walk_fault_o},      32'd0);
    endtask

    // Presents a request and returns at the negedge just after the accepting edge.
    task automatic start_walk(input logic [31:0] va, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        bus.walk_req_valid_i = 1'b1;
        bus.walk_vaddr_i     = va;
        for (int i = 0; i < 20; i++) begin
            if (bus.walk_req_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.walk_req_valid_i = 1'b0;
    endtask

    // Counts edges from the accepting edge (inclusive) until walk_resp_valid_o is seen.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (!bus.walk_resp_valid_o && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_walk();
        bus.walk_resp_ready_i = 1'b1;
        @(negedge clk);
        bus.walk_resp_ready_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        int lat;
        logic [31:0] a0, a1;
        addr_log.delete();
        start_walk(v.vaddr, ok);
        check("accept", {31'b0, ok}, 32'd1);
        check("req_ready_busy", {31'b0, bus.walk_req_ready_o}, 32'd0);
        wait_resp(lat);
        check("resp_valid", {31'b0, bus.walk_resp_valid_o}, 32'd1);
        check("latency", lat, v.lat);
        check("ppn", {12'b0, bus.walk_ppn_o}, {12'b0, v.ppn});
        check("perm", {29'b0, bus.walk_perm_o}, {29'b0, v.perm});
        check("super", {31'b0, bus.walk_super_o}, {31'b0, v.sup});
        check("fault", {31'b0, bus.walk_fault_o}, {31'b0, v.fault});
        check("nreads", addr_log.size(), v.nreads);
        a0 = (addr_log.size() > 0) ? addr_log[0] : 32'hDEAD_BEEF;
        a1 = (addr_log.size() > 1) ? addr_log[1] : 32'hDEAD_BEEF;
        check("addr0", a0, v.a0);
        if (v.nreads == 2) check("addr1", a1, v.a1);
        $display("walk va=0x%08h ppn=0x%05h perm=%03b super=%0d fault=%0d reads=%0d lat=%0d",
                 v.vaddr, bus.walk_ppn_o, bus.walk_perm_o, bus.walk_super_o,
                 bus.walk_fault_o, addr_log.size(), lat);
        finish_walk();
    endtask

    initial begin
        bit ok;
        int lat;
        logic [31:0] a0, a1;

        //              vaddr          ppn       perm    sup   flt   n  a0       a1       lat
        vecs[0] = '{32'h0000_0ABC, 20'h10000, 3'b111, 1'b0, 1'b0, 2, 32'h400, 32'h800, 5};
        vecs[1] = '{32'h0000_2000, 20'h12000, 3'b011, 1'b0, 1'b0, 2, 32'h400, 32'h808, 5};
        vecs[2] = '{32'h0000_1000, 20'h11000, 3'b111, 1'b0, 1'b0, 2, 32'h400, 32'h804, 5};
        vecs[3] = '{32'h0000_3000, 20'h00000, 3'b000, 1'b0, 1'b1, 2, 32'h400, 32'h80C, 5};
        vecs[4] = '{32'h0040_0000, 20'h00000, 3'b000, 1'b0, 1'b1, 1, 32'h404, 32'h0,   3};
        vecs[5] = '{32'h0080_0000, 20'h00000, 3'b000, 1'b0, 1'b1, 1, 32'h408, 32'h0,   3};
        vecs[6] = '{32'h00C0_5123, 20'h00405, 3'b101, 1'b1, 1'b0, 1, 32'h40C, 32'h0,   3};
        vecs[7] = '{32'h0100_0000, 20'h00000, 3'b000, 1'b0, 1'b1, 1, 32'h410, 32'h0,   3};
        vecs[8] = '{32'h0140_0000, 20'h00000, 3'b000, 1'b0, 1'b1, 1, 32'h414, 32'h0,   3};
        vecs[9] = '{32'h0000_4000, 20'h00000, 3'b000, 1'b0, 1'b1, 2, 32'h400, 32'h810, 5};

        bus.walk_req_valid_i  = 1'b0;
        bus.walk_vaddr_i      = '0;
        bus.walk_resp_ready_i = 1'b0;
        bus.mem_req_ready_i   = 1'b1;
        bus.mem_data_i        = '0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        check("req_ready_after_reset", {31'b0, bus.walk_req_ready_o}, 32'd1);
        $display("reset released, walk_req_ready_o=%0d", bus.walk_req_ready_o);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Memory request stall then response backpressure.
        addr_log.delete();
        bus.mem_req_ready_i = 1'b0;
        start_walk(32'h0000_0ABC, ok);
        check("bp_accept", {31'b0, ok}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            check("bp_mem_valid", {31'b0, bus.mem_req_valid_o}, 32'd1);
            check("bp_mem_addr", bus.mem_addr_o, 32'h400);
            @(negedge clk);
        end
        bus.mem_req_ready_i = 1'b1;
        wait_resp(lat);
        check("bp_resp_valid", {31'b0, bus.walk_resp_valid_o}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'b0, bus.walk_resp_valid_o}, 32'd1);
            check("bp_hold_ppn", {12'b0, bus.walk_ppn_o}, 32'h10000);
            check("bp_hold_perm", {29'b0, bus.walk_perm_o}, 32'd7);
            check("bp_hold_fault", {31'b0, bus.walk_fault_o}, 32'd0);
        end
        a0 = (addr_log.size() > 0) ? addr_log[0] : 32'hDEAD_BEEF;
        a1 = (addr_log.size() > 1) ? addr_log[1] : 32'hDEAD_BEEF;
        check("bp_addr0", a0, 32'h400);
        check("bp_addr1", a1, 32'h800);
        finish_walk();
        check("bp_resp_dropped", {31'b0, bus.walk_resp_valid_o}, 32'd0);
        check("bp_idle_ready", {31'b0, bus.walk_req_ready_o}, 32'd1);
        $display("backpressure walk ppn=0x10000 held 5 cycles, reads=%0d", addr_log.size());

        // Reset while waiting for the level-2 PTE.
        addr_log.delete();
        start_walk(32'h0000_0ABC, ok);
        check("rst_accept", {31'b0, ok}, 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_resp_ready_o && addr_log.size() == 2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst_reach_l2_wait", {31'b0, ok}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("midwalk_reset");
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready_back", {31'b0, bus.walk_req_ready_o}, 32'd1);
        $display("reset in L2_WAIT, outputs cleared");
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
